vector_mem_sequencer: RTL
=========================

Name: vector_mem_sequencer

Overview:
Multi-beat sequencer for vector load/store instructions (modeSel=1 with memToReg or memWrite from the control unit).
It splits one VLANES-wide vector access into VLANES single-lane accesses on the shared scalar data-memory port.
It stalls the pipeline until the access is done, then presents the assembled vector with a one-cycle regWriteV pulse.
It sits between the decode/execute stage and data memory, in front of the vector register file write port.

Parameters:
VLANES, 4, lanes per vector (>=2)
DATA_W, 32, lane width in bits
ADDR_W, 32, byte address width
STRIDE, 4, byte increment between consecutive lanes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  vector memory instruction present in stage (one-cycle qualified by pipeline)
isStore  in  1  1=store vector, 0=load vector; sampled with start
baseAddr  in  ADDR_W  lane-0 byte address; sampled with start
storeData  in  VLANES*DATA_W  vector to store, lane i at bits [i*DATA_W +: DATA_W]; sampled with start
memReq  out  1  request valid on memory port
memWe  out  1  write enable, qualified by memReq
memAddr  out  ADDR_W  lane address
memWdata  out  DATA_W  lane write data
memGnt  in  1  memory accepts current request this cycle
memRdata  in  DATA_W  read data, valid exactly one cycle after a granted read
loadData  out  VLANES*DATA_W  assembled load vector
regWriteV  out  1  one-cycle pulse: write loadData to vector register
done  out  1  one-cycle pulse: operation complete (load or store)
stall  out  1  hold fetch/decode/execute

Behaviour:
- States: IDLE, BUSY, DRAIN, DONE. Encoding is local to the block.
- Reset (synchronous):
  - state=IDLE, beat=0.
  - memReq=0, memWe=0, memAddr=0, memWdata=0.
  - loadData=0, regWriteV=0, done=0, stall=0.
- IDLE:
  - stall = start (combinational), so the instruction is held in the cycle it is first seen.
  - On start: latch isStore, baseAddr and storeData; beat=0; go to BUSY.
- BUSY:
  - memReq=1, memWe=isStore.
  - memAddr = base + beat*STRIDE, modulo 2^ADDR_W (wrap-around, no error).
  - memWdata = latched lane[beat].
  - stall=1.
  - On memGnt: beat increments.
    - Store, beat==VLANES-1 granted: go to DONE.
    - Load, beat==VLANES-1 granted: go to DRAIN.
  - memGnt low: hold memAddr, memWdata and beat unchanged; stall persists.
- Load capture:
  - A granted read at beat k sets a pending flag and lane index k.
  - In the next cycle, memRdata is written into loadData lane k.
  - Back-to-back grants therefore give one lane per cycle.
- DRAIN (load only):
  - memReq=0, stall=1.
  - Captures the last lane; next state DONE.
- DONE:
  - done=1.
  - regWriteV=!isStore.
  - stall=0, memReq=0.
  - The pipeline advances this cycle; next state IDLE unconditionally.
  - start is ignored in DONE, because the new instruction is presented in the following IDLE cycle.
- Best-case latency from the start cycle:
  - Store: VLANES+1 cycles to the done pulse.
  - Load: VLANES+2 cycles to the done pulse.
- loadData:
  - Holds its value until lanes are overwritten by the next load.
  - Lanes are not cleared at the start of a load.
  - A store never modifies loadData.
- start while BUSY/DRAIN: ignored. The pipeline is stalled, so this case only arises through a bench violation.
- rst mid-operation: immediate return to IDLE, memReq deasserted in the next cycle, no done/regWriteV pulse, loadData cleared.
- Scalar memory ops never assert start; they pass through outside this block.

Decomposition:
- Shared package (vec_pkg):
  - VLANES, DATA_W, ADDR_W defaults.
  - State enum type.
  - lane-slice helper function.
- Optional sub-module lane_capture: pending flag, lane index and loadData register bank. Everything else stays in one FSM module.

Test Plan:
- Store, memGnt tied 1: start, isStore=1, baseAddr=0x100, lanes {0x11,0x22,0x33,0x44} -> writes to 0x100/0x104/0x108/0x10C with matching data, one per cycle; done at cycle 5; regWriteV=0; stall high cycles 0-4.
- Load, memGnt tied 1: baseAddr=0x200, memory returns 0xA0..0xA3 -> loadData={0xA3,0xA2,0xA1,0xA0}; regWriteV and done pulse at cycle 6; stall low in that cycle.
- Load with memGnt low in every other cycle -> addresses held while ungranted; lanes still correctly ordered; done only after 4 grants plus drain.
- Address wrap: baseAddr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst asserted during BUSY at beat 2 -> next cycle memReq=0, stall=0, loadData=0; no done; a following start runs normally from beat 0.
- start held high through DONE -> exactly one operation per DONE→IDLE return; the second start begins the cycle after DONE.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared defaults, FSM state type and lane-slice helper for the vector memory sequencer
package vec_pkg;
  localparam int VEC_LANES  = 4;
  localparam int VEC_DATA_W = 32;
  localparam int VEC_ADDR_W = 32;
  localparam int VEC_STRIDE = 4;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} vms_state_e;
  function automatic logic [VEC_DATA_W-1:0] lane(input logic [VEC_LANES*VEC_DATA_W-1:0] v, input int unsigned i);
    return v[i*VEC_DATA_W +: VEC_DATA_W];
  endfunction
endpackage

// File: rtl/lane_capture.sv
// lane_capture: writes read data into the granted lane one cycle after the grant
module lane_capture
  import vec_pkg::*;
#(
  parameter int VLANES = VEC_LANES,
  parameter int DATA_W = VEC_DATA_W,
  parameter int IW     = $clog2(VLANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_i,
  input  logic [IW-1:0]            idx_i,
  input  logic [DATA_W-1:0]        rdata_i,
  output logic [VLANES*DATA_W-1:0] data_o
);
  logic                     pend_q;
  logic [IW-1:0]            idx_q;
  logic [VLANES*DATA_W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      pend_q <= cap_i;
      idx_q  <= idx_i;
      for (int i = 0; i < VLANES; i++)
        if (pend_q && idx_q == IW'(i)) data_q[i*DATA_W +: DATA_W] <= rdata_i;
    end
  end
  assign data_o = data_q;
endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: splits one vector load/store into per-lane scalar memory beats and stalls until done
module vector_mem_sequencer
  import vec_pkg::*;
#(
  parameter int VLANES = VEC_LANES,
  parameter int DATA_W = VEC_DATA_W,
  parameter int ADDR_W = VEC_ADDR_W,
  parameter int STRIDE = VEC_STRIDE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     isStore,
  input  logic [ADDR_W-1:0]        baseAddr,
  input  logic [VLANES*DATA_W-1:0] storeData,
  output logic                     memReq,
  output logic                     memWe,
  output logic [ADDR_W-1:0]        memAddr,
  output logic [DATA_W-1:0]        memWdata,
  input  logic                     memGnt,
  input  logic [DATA_W-1:0]        memRdata,
  output logic [VLANES*DATA_W-1:0] loadData,
  output logic                     regWriteV,
  output logic                     done,
  output logic                     stall
);
  localparam int BW = $clog2(VLANES);
  vms_state_e               state_q;
  logic [BW-1:0]            beat_q;
  logic                     st_q, req_q, we_q, done_q, rwv_q, last;
  logic [ADDR_W-1:0]        addr_q;
  logic [VLANES*DATA_W-1:0] wbuf_q;
  assign last = beat_q == BW'(VLANES-1);
  // Store data shifts down one lane per grant so lane 0 is always the current beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      st_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      done_q  <= 1'b0;
      rwv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rwv_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_BUSY;
          st_q    <= isStore;
          beat_q  <= '0;
          req_q   <= 1'b1;
          we_q    <= isStore;
          addr_q  <= baseAddr;
          wbuf_q  <= storeData;
        end
        S_BUSY: if (memGnt) begin
          beat_q <= beat_q + 1'b1;
          addr_q <= addr_q + ADDR_W'(STRIDE);
          wbuf_q <= wbuf_q >> DATA_W;
          if (last) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= st_q ? S_DONE : S_DRAIN;
            done_q  <= st_q;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          rwv_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign memReq    = req_q;
  assign memWe     = we_q;
  assign memAddr   = addr_q;
  assign memWdata  = wbuf_q[DATA_W-1:0];
  assign done      = done_q;
  assign regWriteV = rwv_q;
  assign stall     = state_q == S_IDLE ? start : state_q != S_DONE;
  lane_capture #(.VLANES(VLANES), .DATA_W(DATA_W), .IW(BW)) u_cap (
    .clk(clk),
    .rst(rst),
    .cap_i(state_q == S_BUSY && memGnt && !st_q),
    .idx_i(beat_q),
    .rdata_i(memRdata),
    .data_o(loadData)
  );
endmodule
